seven_seg_display_arbiter: RTL and testbench

Time-sliced round-robin arbiter that shares the board's eight seven-segment digits among up to eight requesters, each presenting a 32-bit hex value. It sits between lab datapaths (counters, switch readers, status monitors) and the seven-segment and LED pins of the top level. Grant, owner status and pending requests are mirrored on the green and red LEDs.

---
 rtl/seven_seg_arb_pkg.sv | 14 +
 rtl/hex_to_seven_seg.sv | 33 +++
 rtl/seven_seg_display_arbiter.sv | 132 +++++++++++++
 tb/tb_seven_seg_display_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Imported by the arbiter top and the hex decoder.
package seven_seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SWITCH
  } arb_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int MAX_REQ = 8;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Segment order is {g,f,e,d,c,b,a}.
module hex_to_seven_seg
  import seven_seg_arb_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    unique case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin time-sliced arbiter sharing eight seven-segment digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits during a grant.
module seven_seg_display_arbiter
  import seven_seg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                     CLOCK_50_I,
  input  logic                     RESET_I,
  input  logic [NUM_REQ-1:0]       REQ_I,
  input  logic [NUM_REQ-1:0][31:0] DATA_I,
  output logic [NUM_REQ-1:0]       GRANT_O,
  output logic [7:0][6:0]          SEVEN_SEGMENT_N_O,
  output logic [8:0]               LED_GREEN_O,
  output logic [17:0]              LED_RED_O
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

  arb_state_e         state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      last_owner;
  logic [IW-1:0]      winner;
  logic               found;
  logic [NUM_REQ-1:0] win_oh;
  logic [CW-1:0]      hold_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] led_red;
  logic               competitor;
  logic [31:0]        data_sel;
  logic [7:0][6:0]    dec;
  logic [7:0][6:0]    seg_d;
  logic [7:0][6:0]    seg_q;

  // Search starts just past the last owner, so it ends up lowest priority.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = last_owner;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (!found && REQ_I[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
    win_oh = NUM_REQ'(1) << winner;
  end

  assign competitor = |(REQ_I & ~grant);
  assign data_sel   = DATA_I[owner];

  for (genvar k = 0; k < 8; k++) begin : g_dec
    hex_to_seven_seg u_dec (
      .hex   (data_sel[4*k +: 4]),
      .seg_n (dec[k])
    );
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead  = 1'b1;
    seg_d = dec;
    for (int k = 7; k >= 1; k--) begin
      if (lead && data_sel[4*k +: 4] == 4'h0) begin
        seg_d[k] = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`else
    seg_d = dec;
`endif
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      hold_cnt   <= '0;
      seg_q      <= {8{SEG_BLANK}};
      led_red    <= '0;
    end else begin
      led_red <= REQ_I & ~grant;
      seg_q   <= (state == GRANT) ? seg_d : {8{SEG_BLANK}};
      unique case (state)
        IDLE, SWITCH: begin
          if (found) begin
            state      <= GRANT;
            owner      <= winner;
            last_owner <= winner;
            grant      <= win_oh;
            hold_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!REQ_I[owner] ||
              (hold_cnt == HOLD_MAX && competitor)) begin
            state <= SWITCH;
            grant <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign GRANT_O           = grant;
  assign SEVEN_SEGMENT_N_O = seg_q;
  assign LED_RED_O         = 18'(led_red);

  always_comb begin
    LED_GREEN_O                = '0;
    LED_GREEN_O[NUM_REQ-1:0]   = grant;
    LED_GREEN_O[8]             = (state == GRANT);
  end

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed bench for seven_seg_display_arbiter (NUM_REQ=4, HOLD_CYCLES=8).
// Honours LEADING_ZERO_BLANK_EN for the expected digit images.
module tb_seven_seg_display_arbiter;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0][31:0] data;
  logic [3:0]      grant;
  logic [7:0][6:0] segs;
  logic [8:0]      led_g;
  logic [17:0]     led_r;

  int checks;
  int failures;

  seven_seg_display_arbiter #(
    .NUM_REQ     (4),
    .HOLD_CYCLES (8)
  ) dut (
    .CLOCK_50_I        (clk),
    .RESET_I           (rst),
    .REQ_I             (req),
    .DATA_I            (data),
    .GRANT_O           (grant),
    .SEVEN_SEGMENT_N_O (segs),
    .LED_GREEN_O       (led_g),
    .LED_RED_O         (led_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic       chk_red;
    logic [3:0] exp_red;
  } vec_t;

  vec_t vecs [26];

  localparam logic [55:0] BLANK_ALL = {8{7'h7F}};

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [55:0] exp_segs(input logic [31:0] d);
    logic [55:0] r;
    logic lead;
    for (int k = 0; k < 8; k++) r[7*k +: 7] = seg_of(d[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (lead && d[4*k +: 4] == 4'h0) r[7*k +: 7] = 7'h7F;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    data     = '0;

    for (int i = 0; i < 26; i++) begin
      vecs[i].req       = 4'b0101;
      vecs[i].exp_grant = (i < 8)  ? 4'b0001 :
                          (i == 8) ? 4'b0000 :
                          (i < 17) ? 4'b0100 :
                          (i == 17) ? 4'b0000 : 4'b0001;
      vecs[i].chk_red   = (i >= 1 && i <= 7) || (i >= 10 && i <= 16);
      vecs[i].exp_red   = (i < 8) ? 4'b0100 : 4'b0001;
    end

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_segs",  64'(segs),  64'(BLANK_ALL));
    chk("rst_green", 64'(led_g), 64'h0);
    chk("rst_red",   64'(led_r), 64'h0);

    // First grant and segment latency
    data[0] = 32'h0000_1234;
    req     = 4'b0001;
    step();
    chk("first_grant", 64'(grant), 64'h1);
    chk("first_segs_blank", 64'(segs), 64'(BLANK_ALL));
    chk("first_green", 64'(led_g), 64'h101);
    step();
    chk("first_segs", 64'(segs), 64'(exp_segs(32'h0000_1234)));
    chk("first_dig0", 64'(segs[0]), 64'(7'h19));
`ifdef LEADING_ZERO_BLANK_EN
    chk("first_dig7", 64'(segs[7]), 64'(7'h7F));
`else
    chk("first_dig7", 64'(segs[7]), 64'(7'h40));
`endif

    // Round-robin alternation with preemption
    do_reset();
    for (int i = 0; i < 26; i++) begin
      req = vecs[i].req;
      step();
      chk($sformatf("rr_grant[%0d]", i), 64'(grant),
          64'(vecs[i].exp_grant));
      if (vecs[i].chk_red)
        chk($sformatf("rr_red[%0d]", i), 64'(led_r),
            64'(vecs[i].exp_red));
    end

    // Owner drop hands over after a one-cycle gap
    do_reset();
    data[1] = 32'hABCD_EF01;
    req     = 4'b0011;
    step();
    step();
    step();
    chk("drop_pre", 64'(grant), 64'h1);
    req = 4'b0010;
    step();
    chk("drop_switch", 64'(grant), 64'h0);
    chk("drop_busy", 64'(led_g), 64'h0);
    step();
    chk("drop_grant1", 64'(grant), 64'h2);
    chk("drop_segs_blank", 64'(segs), 64'(BLANK_ALL));
    step();
    chk("drop_segs", 64'(segs), 64'(exp_segs(32'hABCD_EF01)));
    chk("drop_dig1", 64'(segs[1]), 64'(7'h40));

    // Sole requester keeps the grant past slice expiry
    do_reset();
    data[2] = 32'h0000_0005;
    req     = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("sole[%0d]", i), 64'(grant), 64'h4);
    end
    chk("sole_segs", 64'(segs), 64'(exp_segs(32'h0000_0005)));
    data[2] = 32'h0000_0009;
    step();
    chk("data_latency", 64'(segs), 64'(exp_segs(32'h0000_0009)));

    // Saturated counter preempts immediately once a competitor shows up
    req = 4'b0101;
    step();
    chk("sat_switch", 64'(grant), 64'h0);
    step();
    chk("sat_next", 64'(grant), 64'h1);
    step();

    // Reset mid-grant
    rst = 1'b1;
    step();
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_segs",  64'(segs),  64'(BLANK_ALL));
    chk("mid_rst_green", 64'(led_g), 64'h0);
    chk("mid_rst_red",   64'(led_r), 64'h0);
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("post_rst_grant", 64'(grant), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
